// File: rtl/bank_dist_pkg.sv
// Shared types and width helpers for the bank write sequencer and its block ownership tracker.
package bank_dist_pkg;

  localparam int DEFAULT_BANK_COUNT  = 3;
  localparam int DEFAULT_BLOCK_DEPTH = 480;
  localparam int DEFAULT_BLOCK_COUNT = 2;

  // Width of an index that enumerates n items; a single item still needs one bit.
  function automatic int calc_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_addr_width(input int depth, input int count);
    return $clog2(depth * count);
  endfunction

  localparam int DEFAULT_ADDR_WIDTH    = calc_addr_width(DEFAULT_BLOCK_DEPTH, DEFAULT_BLOCK_COUNT);
  localparam int DEFAULT_BLK_IDX_WIDTH = calc_idx_width(DEFAULT_BLOCK_COUNT);

  typedef enum logic {
    FILL      = 1'b0,
    WAIT_FREE = 1'b1
  } state_t;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] bank_addr_t;

endpackage

// File: rtl/block_ownership_tracker.sv
// Full flags for the block ring: set on block completion, cleared by reader release; set beats release.
module block_ownership_tracker
  import bank_dist_pkg::*;
#(
  parameter int BLOCK_COUNT   = DEFAULT_BLOCK_COUNT,
  parameter int BLK_IDX_WIDTH = calc_idx_width(BLOCK_COUNT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_valid,
  input  logic [BLK_IDX_WIDTH-1:0] set_idx,
  input  logic [BLOCK_COUNT-1:0]   rel_mask,
  output logic [BLOCK_COUNT-1:0]   full,
  output logic [BLOCK_COUNT-1:0]   full_next
);

  // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    full_next = full & ~rel_mask;
    // Applied after the release so a completion on the same edge keeps the block owned.
    if (set_valid) full_next[set_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) full <= '0;
    else     full <= full_next;
  end

endmodule

// File: rtl/bank_write_sequencer.sv
// Deals a valid/ready pixel stream round-robin across banks, filling a ring of blocks per bank.
module bank_write_sequencer
  import bank_dist_pkg::*;
#(
  parameter int BANK_COUNT  = DEFAULT_BANK_COUNT,
  parameter int BLOCK_DEPTH = DEFAULT_BLOCK_DEPTH,
  parameter int BLOCK_COUNT = DEFAULT_BLOCK_COUNT,
  parameter int DATA_WIDTH  = 24,
  parameter int ADDR_WIDTH  = calc_addr_width(BLOCK_DEPTH, BLOCK_COUNT)
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  input  logic                          I_valid,
  input  logic [DATA_WIDTH-1:0]         I_data,
  input  logic                          I_sof,
  output logic                          O_ready,
  input  logic [BLOCK_COUNT-1:0]        I_release,
  output logic [BANK_COUNT-1:0]         O_bank_wr_en,
  output logic [ADDR_WIDTH-1:0]         O_bank_addr [0:BANK_COUNT-1],
  output logic [DATA_WIDTH-1:0]         O_bank_data,
  output logic                          O_block_done,
  output logic [$clog2(BLOCK_COUNT)-1:0] O_done_block,
  output logic [BLOCK_COUNT-1:0]        O_full
);

  localparam int BANK_W = calc_idx_width(BANK_COUNT);
  localparam int WORD_W = calc_idx_width(BLOCK_DEPTH);
  localparam int BLK_W  = calc_idx_width(BLOCK_COUNT);

  state_t state, state_next;

  logic [BANK_W-1:0]     bank_idx, bank_next, wr_bank;
  logic [WORD_W-1:0]     word_idx, word_next, wr_word;
  logic [BLK_W-1:0]      blk_idx, blk_next, blk_adv;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  accept, bank_last, complete;
  logic [BLOCK_COUNT-1:0] full_next;

  block_ownership_tracker #(
    .BLOCK_COUNT   (BLOCK_COUNT),
    .BLK_IDX_WIDTH (BLK_W)
  ) u_tracker (
    .clk       (I_clk),
    .rst       (I_rst),
    .set_valid (complete),
    .set_idx   (blk_idx),
    .rel_mask  (I_release),
    .full      (O_full),
    .full_next (full_next)
  );

  // FILL is only ever held while the current block is free, so this equals !I_rst && !O_full[blk_idx].
  assign O_ready = !I_rst && (state == FILL);
  assign accept  = I_valid && O_ready;

  // Start-of-frame restarts the current block in place at bank 0, word 0.
  always_comb begin
    wr_bank   = I_sof ? '0 : bank_idx;
    wr_word   = I_sof ? '0 : word_idx;
    wr_addr   = ADDR_WIDTH'(blk_idx) * ADDR_WIDTH'(BLOCK_DEPTH) + ADDR_WIDTH'(wr_word);
    bank_last = (bank_idx == BANK_W'(BANK_COUNT - 1));
    complete  = accept && !I_sof && bank_last && (word_idx == WORD_W'(BLOCK_DEPTH - 1));
    blk_adv   = (blk_idx == BLK_W'(BLOCK_COUNT - 1)) ? '0 : blk_idx + BLK_W'(1);

    bank_next = bank_idx;
    word_next = word_idx;
    blk_next  = blk_idx;
    if (accept) begin
      if (I_sof) begin
        if (BANK_COUNT == 1) begin
          bank_next = '0;
          word_next = WORD_W'(1);
        end else begin
          bank_next = BANK_W'(1);
          word_next = '0;
        end
      end else if (complete) begin
        bank_next = '0;
        word_next = '0;
        blk_next  = blk_adv;
      end else if (bank_last) begin
        bank_next = '0;
        word_next = word_idx + WORD_W'(1);
      end else begin
        bank_next = bank_idx + BANK_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:      if (full_next[blk_next]) state_next = WAIT_FREE;
      WAIT_FREE: if (!full_next[blk_idx]) state_next = FILL;
      default:   state_next = FILL;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) state <= FILL;
    else       state <= state_next;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      bank_idx     <= '0;
      word_idx     <= '0;
      blk_idx      <= '0;
      O_bank_wr_en <= '0;
      O_bank_data  <= '0;
      O_block_done <= 1'b0;
      O_done_block <= '0;
      // NOTE: the address array is a small bank of output registers, not a RAM, so it is reset like any flop.
      for (int b = 0; b < BANK_COUNT; b++) O_bank_addr[b] <= '0;
    end else begin
      bank_idx     <= bank_next;
      word_idx     <= word_next;
      blk_idx      <= blk_next;
      O_bank_wr_en <= accept ? (BANK_COUNT'(1) << wr_bank) : '0;
      O_block_done <= complete;
      if (accept) begin
        O_bank_addr[wr_bank] <= wr_addr;
        O_bank_data          <= I_data;
      end
      if (complete) O_done_block <= blk_idx;
    end
  end

endmodule

// File: tb/tb_bank_write_sequencer.sv
// Directed self-checking bench for bank_write_sequencer at the default 3 banks x 480 words x 2 blocks.
module tb_bank_write_sequencer;
  import bank_dist_pkg::*;

  logic             I_clk = 1'b0;
  logic             I_rst;
  logic             I_valid;
  logic [23:0]      I_data;
  logic             I_sof;
  logic             O_ready;
  logic [1:0]       I_release;
  logic [2:0]       O_bank_wr_en;
  bank_addr_t       O_bank_addr [0:2];
  logic [23:0]      O_bank_data;
  logic             O_block_done;
  logic [0:0]       O_done_block;
  logic [1:0]       O_full;

  int checks = 0;
  int errors = 0;

  bank_write_sequencer dut (
    .I_clk        (I_clk),
    .I_rst        (I_rst),
    .I_valid      (I_valid),
    .I_data       (I_data),
    .I_sof        (I_sof),
    .O_ready      (O_ready),
    .I_release    (I_release),
    .O_bank_wr_en (O_bank_wr_en),
    .O_bank_addr  (O_bank_addr),
    .O_bank_data  (O_bank_data),
    .O_block_done (O_block_done),
    .O_done_block (O_done_block),
    .O_full       (O_full)
  );

  always #5 I_clk = ~I_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  // One pixel offered for one edge; outputs are sampled 1 time unit after that edge.
  task automatic push(input logic [23:0] d, input logic sof, input logic [1:0] rel);
    I_valid   = 1'b1;
    I_data    = d;
    I_sof     = sof;
    I_release = rel;
    tick();
    I_valid   = 1'b0;
    I_sof     = 1'b0;
    I_release = 2'b00;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},  32'(O_bank_wr_en), 32'h0);
    check({tag, "_addr0"},  32'(O_bank_addr[0]), 32'h0);
    check({tag, "_addr1"},  32'(O_bank_addr[1]), 32'h0);
    check({tag, "_addr2"},  32'(O_bank_addr[2]), 32'h0);
    check({tag, "_data"},   32'(O_bank_data), 32'h0);
    check({tag, "_done"},   32'(O_block_done), 32'h0);
    check({tag, "_dblk"},   32'(O_done_block), 32'h0);
    check({tag, "_full"},   32'(O_full), 32'h0);
  endtask

  initial begin
    int done_seen;

    I_rst = 1'b1; I_valid = 1'b0; I_data = '0; I_sof = 1'b0; I_release = 2'b00;
    tick();
    check("rst_ready_low", 32'(O_ready), 32'h0);
    tick();
    check_all_zero("rst");
    I_rst = 1'b0;
    #1;
    check("rst_ready_after", 32'(O_ready), 32'h1);

    // Nine accepts: banks 0,1,2 repeating, address = pixel/3.
    for (int i = 0; i < 9; i++) begin
      push(24'(i), 1'b0, 2'b00);
      check($sformatf("rr_wr_en_%0d", i), 32'(O_bank_wr_en), 32'(1 << (i % 3)));
      check($sformatf("rr_addr_%0d", i), 32'(O_bank_addr[i % 3]), 32'(i / 3));
      check($sformatf("rr_data_%0d", i), 32'(O_bank_data), 32'(i));
    end
    tick();
    check("idle_wr_en", 32'(O_bank_wr_en), 32'h0);
    check("idle_addr_hold", 32'(O_bank_addr[2]), 32'd2);
    check("idle_data_hold", 32'(O_bank_data), 32'd8);

    // Complete block 0 (pixels 9..1439).
    done_seen = 0;
    for (int i = 9; i < 1439; i++) begin
      push(24'(i), 1'b0, 2'b00);
      if (O_block_done) done_seen++;
    end
    check("blk0_no_early_done", 32'(done_seen), 32'd0);
    push(24'd1439, 1'b0, 2'b00);
    check("blk0_last_wr_en", 32'(O_bank_wr_en), 32'b100);
    check("blk0_last_addr", 32'(O_bank_addr[2]), 32'd479);
    check("blk0_done", 32'(O_block_done), 32'h1);
    check("blk0_done_idx", 32'(O_done_block), 32'h0);
    check("blk0_full", 32'(O_full), 32'b01);
    check("blk0_ready", 32'(O_ready), 32'h1);
    push(24'd1440, 1'b0, 2'b00);
    check("blk1_first_wr_en", 32'(O_bank_wr_en), 32'b001);
    check("blk1_first_addr", 32'(O_bank_addr[0]), 32'd480);
    check("blk1_done_pulse_1cyc", 32'(O_block_done), 32'h0);

    // Complete block 1 with no release: ring is then full and the sequencer waits.
    for (int i = 1441; i < 2880; i++) push(24'(i), 1'b0, 2'b00);
    check("blk1_last_addr", 32'(O_bank_addr[2]), 32'd959);
    check("blk1_done", 32'(O_block_done), 32'h1);
    check("blk1_done_idx", 32'(O_done_block), 32'h1);
    check("both_full", 32'(O_full), 32'b11);
    check("stall_ready", 32'(O_ready), 32'h0);
    check("stall_state", 32'(dut.state), 32'(WAIT_FREE));
    I_valid = 1'b1; I_data = 24'h123456;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_no_wr_%0d", i), 32'(O_bank_wr_en), 32'h0);
      check($sformatf("stall_ready_%0d", i), 32'(O_ready), 32'h0);
    end
    I_valid = 1'b0;
    check("stall_data_hold", 32'(O_bank_data), 32'd2879);
    I_release = 2'b01;
    #1;
    check("rel_ready_same_cycle", 32'(O_ready), 32'h0);
    tick();
    I_release = 2'b00;
    check("rel0_full", 32'(O_full), 32'b10);
    check("rel0_ready", 32'(O_ready), 32'h1);
    check("rel0_state", 32'(dut.state), 32'(FILL));
    push(24'hA0A0A0, 1'b0, 2'b00);
    check("after_rel_wr_en", 32'(O_bank_wr_en), 32'b001);
    check("after_rel_addr", 32'(O_bank_addr[0]), 32'd0);
    check("after_rel_data", 32'(O_bank_data), 32'hA0A0A0);

    // Release of block 1 clears it; a second release while clear changes nothing.
    I_release = 2'b10; tick(); I_release = 2'b00;
    check("rel1_full", 32'(O_full), 32'b00);
    I_release = 2'b10; tick(); I_release = 2'b00;
    check("rel1_ignored_full", 32'(O_full), 32'b00);
    check("rel1_ignored_ready", 32'(O_ready), 32'h1);

    // Early release on the completion edge of block 0: set wins.
    for (int i = 1; i < 1439; i++) push(24'(i), 1'b0, 2'b00);
    push(24'd1439, 1'b0, 2'b01);
    check("setwins_done", 32'(O_block_done), 32'h1);
    check("setwins_full", 32'(O_full), 32'b01);
    check("setwins_ready", 32'(O_ready), 32'h1);

    // Five pixels into block 1, then start-of-frame restarts it in place.
    done_seen = 0;
    for (int i = 0; i < 5; i++) push(24'h100 + 24'(i), 1'b0, 2'b00);
    check("pre_sof_addr1", 32'(O_bank_addr[1]), 32'd481);
    push(24'hABCDEF, 1'b1, 2'b00);
    if (O_block_done) done_seen++;
    check("sof_wr_en", 32'(O_bank_wr_en), 32'b001);
    check("sof_addr", 32'(O_bank_addr[0]), 32'd480);
    check("sof_data", 32'(O_bank_data), 32'hABCDEF);
    push(24'h000200, 1'b0, 2'b00);
    if (O_block_done) done_seen++;
    check("post_sof_wr_en", 32'(O_bank_wr_en), 32'b010);
    check("post_sof_addr", 32'(O_bank_addr[1]), 32'd480);
    I_sof = 1'b1; tick(); I_sof = 1'b0;
    check("sof_no_valid_wr_en", 32'(O_bank_wr_en), 32'h0);
    push(24'h000201, 1'b0, 2'b00);
    if (O_block_done) done_seen++;
    check("sof_no_valid_next_wr_en", 32'(O_bank_wr_en), 32'b100);
    check("sof_no_valid_next_addr", 32'(O_bank_addr[2]), 32'd480);
    check("sof_no_done", 32'(done_seen), 32'd0);
    check("sof_full_kept", 32'(O_full), 32'b01);

    // Mid-block reset discards everything.
    I_rst = 1'b1;
    #1;
    check("midrst_ready_low", 32'(O_ready), 32'h0);
    tick();
    check_all_zero("midrst");
    I_rst = 1'b0;
    #1;
    check("midrst_ready_after", 32'(O_ready), 32'h1);
    push(24'h55AA55, 1'b0, 2'b00);
    check("midrst_next_wr_en", 32'(O_bank_wr_en), 32'b001);
    check("midrst_next_addr", 32'(O_bank_addr[0]), 32'd0);
    check("midrst_next_data", 32'(O_bank_data), 32'h55AA55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
